// File: rtl/vram_fetch_seq.sv
// Video-RAM byte fetch sequencer: replays one BYTES*8-bit VRAM word as successive CPC byte fetches.
// Optional statistics outputs (fetch_cnt, blank_cnt) are enabled by defining VRAM_FETCH_STATS_EN.
module vram_fetch_seq #(
   parameter int BYTES  = 2,
   parameter int ADDR_W = 15,
   parameter int LANE_W = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cpu_n,
   input  logic                 ras_n,
   input  logic                 cas_n,
   input  logic                 crtc_de,
   input  logic                 shift_en,
   input  logic [ADDR_W-1:0]    crtc_addr,
   input  logic [BYTES*8-1:0]   vram_din,
   output logic [ADDR_W-1:0]    vram_addr,
   output logic [7:0]           vram_d,
   output logic                 vram_d_stb,
   output logic [LANE_W-1:0]    lane
`ifdef VRAM_FETCH_STATS_EN
   ,
   output logic [15:0]          fetch_cnt,
   output logic [15:0]          blank_cnt
`endif
);

   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);

   logic       cas_n_old;
   logic [7:0] held;
   logic       fetch;
   logic       advance;
   logic       at_last;
   logic [7:0] cur_byte;
   logic [7:0] prev_byte;
   logic [7:0] fetch_byte;

   assign fetch      = cpu_n & ~ras_n & ~cas_n;
   assign advance    = cpu_n & ~ras_n & ~cas_n_old & cas_n;
   assign at_last    = (lane == LAST_LANE);
   assign vram_d_stb = fetch & cas_n_old & ~reset;

   // Lane select written as a compare loop so non-power-of-2 BYTES never indexes past the word.
   always_comb begin
      cur_byte  = '0;
      prev_byte = '0;
      for (int unsigned i = 0; i < BYTES; i++) begin
         if (LANE_W'(i) == lane)
            cur_byte = vram_din[8*i +: 8];
         if (LANE_W'(i + 1) == lane)
            prev_byte = vram_din[8*i +: 8];
      end
   end

   always_comb begin
      fetch_byte = cur_byte;
      if (shift_en)
         fetch_byte = (lane == '0) ? held : prev_byte;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vram_addr <= '0;
         vram_d    <= '0;
         lane      <= '0;
         held      <= '0;
         cas_n_old <= 1'b1;
      end else begin
         cas_n_old <= cas_n;
         if (!cpu_n) begin
            lane <= '0;
         end else begin
            vram_addr <= crtc_addr;
            if (advance && !at_last)
               lane <= lane + LANE_W'(1);
            if (fetch) begin
               vram_d <= fetch_byte;
               // Top lane is carried into the next access as its skewed first byte.
               if (shift_en && at_last)
                  held <= crtc_de ? cur_byte : '0;
            end
         end
      end
   end

`ifdef VRAM_FETCH_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_cnt <= '0;
         blank_cnt <= '0;
      end else begin
         if (vram_d_stb)
            fetch_cnt <= fetch_cnt + 16'd1;
         if (fetch && shift_en && at_last && !crtc_de)
            blank_cnt <= blank_cnt + 16'd1;
      end
   end
`endif

endmodule
